if_fetch_unit: RTL

- Instruction fetch stage of the 5-stage pipelined core; sits directly upstream of the IF/ID pipeline register and feeds it.
- Owns the PC register and the single-outstanding-request instruction memory handshake.
- Holds a fetched instruction until decode accepts it, and discards in-flight responses on a branch/jump redirect.
- Drives a NOP bubble (instr = 0) whenever no valid instruction is available.

---
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding imem handshake and
// holds the fetched instruction for IF/ID. Optional counters behind FETCH_PERF_CNT_EN.
module if_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic [WIDTH-1:0] imem_rdata_i,
  input  logic             imem_rvalid_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_if32,
  output logic [WIDTH-1:0] pc_plus4_if32,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]      fetch_cnt_o,
  output logic [31:0]      drop_cnt_o,
`endif
  output logic [1:0]       dbg_state_o
);

  // Handshake: imem_req_o is a one-cycle strobe the memory always accepts; exactly one
  // imem_rvalid_i answers each strobe, 1+ cycles later. Unsolicited rvalid is ignored.
  // IF/ID side: valid_o marks a real instruction; it is taken on any cycle with !stall_i.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_instr, w_instr_nxt;
  logic [WIDTH-1:0] r_pc_plus4, w_pc_plus4_nxt;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_addr;
  logic             w_req;
  logic             w_consume;
  logic             w_drop;
  logic [1:0]       w_unused_lsb;

  assign w_target     = {redirect_pc_i[WIDTH-1:2], 2'b00};
  assign w_unused_lsb = redirect_pc_i[1:0];
  assign w_pc_inc     = r_pc + WIDTH'(4);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_pc_plus4 <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_pc_plus4 <= w_pc_plus4_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_pc_plus4_nxt = r_pc_plus4;
    w_req          = 1'b0;
    w_addr         = r_pc;
    w_consume      = 1'b0;
    w_drop         = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect_i) begin
          w_pc_nxt = w_target;
        end else begin
          w_req       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          w_pc_nxt = w_target;
          if (imem_rvalid_i) begin
            w_drop      = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DROP;
          end
        end else if (imem_rvalid_i) begin
          w_instr_nxt    = imem_rdata_i;
          w_pc_plus4_nxt = w_pc_inc;
          w_state_nxt    = S_HOLD;
        end
      end
      S_DROP: begin
        if (redirect_i) w_pc_nxt = w_target;
        if (imem_rvalid_i) begin
          w_drop      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        // Redirect wins over consumption even when decode is not stalled.
        if (redirect_i) begin
          w_pc_nxt    = w_target;
          w_drop      = 1'b1;
          w_state_nxt = S_REQ;
        end else if (!stall_i) begin
          w_consume   = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_req       = 1'b1;
          w_addr      = w_pc_inc;
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Reset forces the state to S_REQ, so the strobe must be gated off explicitly.
  assign imem_req_o    = w_req & reset_ni;
  assign imem_addr_o   = w_addr;
  assign valid_o       = (r_state == S_HOLD);
  assign instr_if32    = valid_o ? r_instr : '0;
  assign pc_plus4_if32 = valid_o ? r_pc_plus4 : '0;
  assign dbg_state_o   = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_fetch_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_consume) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_drop)    r_drop_cnt  <= r_drop_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign drop_cnt_o  = r_drop_cnt;
`endif

endmodule
